// File: rtl/streaming_result_reorder_buffer_pkg.sv
// Shared types and helpers for the streaming result reorder buffer.
// Optional profiling counters are enabled with STREAMING_REORDER_PROFILING_EN.
package reorder_pkg;

  localparam int DEFAULT_RESULT_WIDTH = 6;
  localparam int DEFAULT_ADDR_WIDTH   = 9;

  typedef struct packed {
    logic pending;
    logic done;
  } slot_state_t;

  function automatic int depth_of(input int addr_width);
    return int'(32'd1 << addr_width);
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/streaming_result_reorder_buffer_if.sv
// Issue, completion and in-order result bundle of the reorder buffer.
// Profiling outputs exist only when STREAMING_REORDER_PROFILING_EN is defined.
interface streaming_result_reorder_buffer_if #(
  parameter int RESULT_WIDTH     = 6,
  parameter int EXTRA_DATA_WIDTH = 1,
  parameter int ADDR_WIDTH       = 9,
  parameter int NUM_LANES        = 2
);
  logic                              issueValid;
  logic [EXTRA_DATA_WIDTH-1:0]       extraDataIn;
  logic [ADDR_WIDTH-1:0]             issueTag;
  logic                              slowDownInput;
  logic [NUM_LANES-1:0]              laneWriteValid;
  logic [NUM_LANES*ADDR_WIDTH-1:0]   laneWriteTag;
  logic [NUM_LANES*RESULT_WIDTH-1:0] laneWriteResult;
  logic                              resultValid;
  logic                              resultReady;
  logic [RESULT_WIDTH-1:0]           result;
  logic [EXTRA_DATA_WIDTH-1:0]       extraDataOut;
  logic [ADDR_WIDTH:0]               occupancy;
  logic                              protocolError;
`ifdef STREAMING_REORDER_PROFILING_EN
  logic [ADDR_WIDTH:0]               peakOccupancy;
  logic [31:0]                       stallCycles;

  modport master (
    output issueValid, extraDataIn, laneWriteValid, laneWriteTag, laneWriteResult, resultReady,
    input  issueTag, slowDownInput, resultValid, result, extraDataOut, occupancy, protocolError,
    input  peakOccupancy, stallCycles
  );
  modport slave (
    input  issueValid, extraDataIn, laneWriteValid, laneWriteTag, laneWriteResult, resultReady,
    output issueTag, slowDownInput, resultValid, result, extraDataOut, occupancy, protocolError,
    output peakOccupancy, stallCycles
  );
`else
  modport master (
    output issueValid, extraDataIn, laneWriteValid, laneWriteTag, laneWriteResult, resultReady,
    input  issueTag, slowDownInput, resultValid, result, extraDataOut, occupancy, protocolError
  );
  modport slave (
    input  issueValid, extraDataIn, laneWriteValid, laneWriteTag, laneWriteResult, resultReady,
    output issueTag, slowDownInput, resultValid, result, extraDataOut, occupancy, protocolError
  );
`endif
endinterface

// File: rtl/streaming_result_reorder_buffer_slot_array.sv
// Per-slot pending/done state plus multi-port result and sideband storage.
// Resolves lane conflicts and flags illegal completions (independent of STREAMING_REORDER_PROFILING_EN).
module reorder_slot_array
  import reorder_pkg::*;
#(
  parameter int RESULT_WIDTH     = DEFAULT_RESULT_WIDTH,
  parameter int EXTRA_DATA_WIDTH = 1,
  parameter int ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int NUM_LANES        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_en,
  input  logic [ADDR_WIDTH-1:0]             issue_tag,
  input  logic [EXTRA_DATA_WIDTH-1:0]       issue_extra,
  input  logic [NUM_LANES-1:0]              lane_valid,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   lane_tag,
  input  logic [NUM_LANES*RESULT_WIDTH-1:0] lane_result,
  input  logic                              release_en,
  input  logic [ADDR_WIDTH-1:0]             head_tag,
  output logic                              head_eligible,
  output logic [RESULT_WIDTH-1:0]           head_result,
  output logic [EXTRA_DATA_WIDTH-1:0]       head_extra,
  output logic                              write_error
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  slot_state_t                 state_r      [DEPTH];
  logic [RESULT_WIDTH-1:0]     result_mem_r [DEPTH];
  logic [EXTRA_DATA_WIDTH-1:0] extra_mem_r  [DEPTH];
  logic [ADDR_WIDTH-1:0]       tag_s        [NUM_LANES];
  logic [RESULT_WIDTH-1:0]     res_s        [NUM_LANES];
  logic [NUM_LANES-1:0]        shadowed_s;
  logic [NUM_LANES-1:0]        accept_s;

  // Unpack the flattened per-lane buses.
  always_comb begin
    for (int j = 0; j < NUM_LANES; j++) begin
      tag_s[j] = lane_tag[lane_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH];
      res_s[j] = lane_result[lane_lsb(j, RESULT_WIDTH) +: RESULT_WIDTH];
    end
  end

  // A lane is shadowed by any lower lane targeting the same tag; only a
  // write to a pending, not-yet-done slot is accepted.
  always_comb begin
    shadowed_s  = '0;
    accept_s    = '0;
    write_error = 1'b0;
    for (int j = 0; j < NUM_LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        shadowed_s[j] = shadowed_s[j] | (lane_valid[i] & (tag_s[i] == tag_s[j]));
      end
      if (lane_valid[j]) begin
        if (!shadowed_s[j] && state_r[tag_s[j]].pending && !state_r[tag_s[j]].done) begin
          accept_s[j] = 1'b1;
        end else begin
          write_error = 1'b1;
        end
      end else begin
        accept_s[j] = 1'b0;
      end
    end
  end

  // Slot state: issue, completion and release never touch the same field of
  // one slot in a single cycle, so their updates can be applied independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        state_r[k] <= '0;
      end
    end else begin
      if (issue_en) begin
        state_r[issue_tag] <= '{pending: 1'b1, done: 1'b0};
      end
      for (int j = 0; j < NUM_LANES; j++) begin
        if (accept_s[j]) begin
          state_r[tag_s[j]].done <= 1'b1;
        end
      end
      if (release_en) begin
        state_r[head_tag].pending <= 1'b0;
      end
    end
  end

  // Payload storage; accepted lanes always target distinct slots.
  always_ff @(posedge clk) begin
    if (issue_en) begin
      extra_mem_r[issue_tag] <= issue_extra;
    end
    for (int j = 0; j < NUM_LANES; j++) begin
      if (accept_s[j]) begin
        result_mem_r[tag_s[j]] <= res_s[j];
      end
    end
  end

  assign head_eligible = state_r[head_tag].pending && state_r[head_tag].done;
  assign head_result   = result_mem_r[head_tag];
  assign head_extra    = extra_mem_r[head_tag];

endmodule

// File: rtl/streaming_result_reorder_buffer.sv
// Reorder buffer top: circular tag issue, in-order release through an output register.
// Define STREAMING_REORDER_PROFILING_EN to add peakOccupancy and stallCycles.
module streaming_result_reorder_buffer
  import reorder_pkg::*;
#(
  parameter int RESULT_WIDTH       = DEFAULT_RESULT_WIDTH,
  parameter int EXTRA_DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
  parameter int NUM_LANES          = 2,
  parameter int ALMOST_FULL_MARGIN = 12
) (
  input logic                               clk,
  input logic                               rst,
  streaming_result_reorder_buffer_if.slave  bus
);
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam int DEPTH     = depth_of(ADDR_WIDTH);
  localparam logic [PTR_WIDTH-1:0] DEPTH_COUNT    = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] SLOW_THRESHOLD = PTR_WIDTH'(DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE        = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0]        tail_r;
  logic [PTR_WIDTH-1:0]        head_r;
  logic [PTR_WIDTH-1:0]        occupancy_s;
  logic [PTR_WIDTH-1:0]        tail_next_s;
  logic [PTR_WIDTH-1:0]        head_next_s;
  logic [PTR_WIDTH-1:0]        occupancy_next_s;
  logic                        has_room_s;
  logic                        issue_accept_s;
  logic                        issue_drop_s;
  logic                        load_s;
  logic                        head_eligible_s;
  logic                        write_error_s;
  logic [RESULT_WIDTH-1:0]     head_result_s;
  logic [EXTRA_DATA_WIDTH-1:0] head_extra_s;
  logic                        valid_r;
  logic [RESULT_WIDTH-1:0]     result_r;
  logic [EXTRA_DATA_WIDTH-1:0] extra_r;
  logic                        slow_r;
  logic                        error_r;

  // The full check uses current occupancy, so a slot freed this cycle is
  // only issuable on the next one.
  assign occupancy_s      = tail_r - head_r;
  assign has_room_s       = occupancy_s < DEPTH_COUNT;
  assign issue_accept_s   = bus.issueValid && has_room_s;
  assign issue_drop_s     = bus.issueValid && !has_room_s;
  assign load_s           = head_eligible_s && (!valid_r || bus.resultReady);
  assign tail_next_s      = issue_accept_s ? (tail_r + PTR_ONE) : tail_r;
  assign head_next_s      = load_s ? (head_r + PTR_ONE) : head_r;
  assign occupancy_next_s = tail_next_s - head_next_s;

  reorder_slot_array #(
    .RESULT_WIDTH     (RESULT_WIDTH),
    .EXTRA_DATA_WIDTH (EXTRA_DATA_WIDTH),
    .ADDR_WIDTH       (ADDR_WIDTH),
    .NUM_LANES        (NUM_LANES)
  ) u_slots (
    .clk           (clk),
    .rst           (rst),
    .issue_en      (issue_accept_s),
    .issue_tag     (tail_r[ADDR_WIDTH-1:0]),
    .issue_extra   (bus.extraDataIn),
    .lane_valid    (bus.laneWriteValid),
    .lane_tag      (bus.laneWriteTag),
    .lane_result   (bus.laneWriteResult),
    .release_en    (load_s),
    .head_tag      (head_r[ADDR_WIDTH-1:0]),
    .head_eligible (head_eligible_s),
    .head_result   (head_result_s),
    .head_extra    (head_extra_s),
    .write_error   (write_error_s)
  );

  // Pointers, almost-full flag and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_r  <= '0;
      head_r  <= '0;
      slow_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      tail_r  <= tail_next_s;
      head_r  <= head_next_s;
      slow_r  <= (occupancy_next_s >= SLOW_THRESHOLD);
      if (issue_drop_s || write_error_s) begin
        error_r <= 1'b1;
      end
    end
  end

  // Output register refills in the same cycle it is popped, so results stream without bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      result_r <= '0;
      extra_r  <= '0;
    end else if (load_s) begin
      valid_r  <= 1'b1;
      result_r <= head_result_s;
      extra_r  <= head_extra_s;
    end else if (bus.resultReady) begin
      valid_r  <= 1'b0;
    end
  end

  assign bus.issueTag      = tail_r[ADDR_WIDTH-1:0];
  assign bus.slowDownInput = slow_r;
  assign bus.resultValid   = valid_r;
  assign bus.result        = result_r;
  assign bus.extraDataOut  = extra_r;
  assign bus.occupancy     = occupancy_s;
  assign bus.protocolError = error_r;

`ifdef STREAMING_REORDER_PROFILING_EN
  logic [PTR_WIDTH-1:0] peak_r;
  logic [31:0]          stall_r;

  // Running occupancy maximum and saturating count of throttled issue attempts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_r  <= '0;
      stall_r <= 32'd0;
    end else begin
      if (occupancy_next_s > peak_r) begin
        peak_r <= occupancy_next_s;
      end
      if (bus.issueValid && slow_r && (stall_r != 32'hFFFF_FFFF)) begin
        stall_r <= stall_r + 32'd1;
      end
    end
  end

  assign bus.peakOccupancy = peak_r;
  assign bus.stallCycles   = stall_r;
`endif

endmodule

// File: tb/tb_streaming_result_reorder_buffer.sv
// Directed and randomized scoreboard bench for streaming_result_reorder_buffer.
module tb_streaming_result_reorder_buffer;
  localparam int RW    = 6;
  localparam int EW    = 1;
  localparam int AW    = 9;
  localparam int NL    = 2;
  localparam int DEPTH = 512;

  typedef struct packed {
    logic [RW-1:0] res;
    logic [EW-1:0] extra;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  streaming_result_reorder_buffer_if #(
    .RESULT_WIDTH(RW), .EXTRA_DATA_WIDTH(EW), .ADDR_WIDTH(AW), .NUM_LANES(NL)
  ) bus ();

  streaming_result_reorder_buffer #(
    .RESULT_WIDTH(RW), .EXTRA_DATA_WIDTH(EW), .ADDR_WIDTH(AW), .NUM_LANES(NL),
    .ALMOST_FULL_MARGIN(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          sb[$];
  logic [AW-1:0] pend_tag[$];
  logic [RW-1:0] pend_res[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            model_tail;
  int            idx;
  logic [RW-1:0] rnd_res;
  logic [EW-1:0] rnd_extra;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    bus.laneWriteValid  = '0;
    bus.laneWriteTag    = '0;
    bus.laneWriteResult = '0;
  endtask

  task automatic issue(input logic [EW-1:0] extra, input logic [RW-1:0] res);
    bus.issueValid  = 1'b1;
    bus.extraDataIn = extra;
    sb.push_back(exp_t'{res: res, extra: extra});
    tick();
    bus.issueValid  = 1'b0;
  endtask

  task automatic lane_write(input logic [NL-1:0] v, input logic [AW-1:0] t0, input logic [AW-1:0] t1,
                            input logic [RW-1:0] r0, input logic [RW-1:0] r1);
    bus.laneWriteValid  = v;
    bus.laneWriteTag    = {t1, t0};
    bus.laneWriteResult = {r1, r0};
    tick();
    idle_lanes();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    pend_tag.delete();
    pend_res.delete();
  endtask

  task automatic drain(input int budget);
    bus.resultReady = 1'b1;
    for (int c = 0; c < budget && sb.size() != 0; c++) tick();
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every accepted output must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (!rst && bus.resultValid && bus.resultReady) begin
      check("output_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_result", 32'(bus.result), 32'(mon_e.res));
        check("out_extra", 32'(bus.extraDataOut), 32'(mon_e.extra));
      end
    end
  end

  initial begin
    bus.issueValid  = 1'b0;
    bus.extraDataIn = '0;
    bus.resultReady = 1'b0;
    idle_lanes();
    do_reset();
    check("rst_valid", 32'(bus.resultValid), 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    check("rst_tag", 32'(bus.issueTag), 32'd0);
    check("rst_slow", 32'(bus.slowDownInput), 32'd0);
    check("rst_err", 32'(bus.protocolError), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_extra", 32'(bus.extraDataOut), 32'd0);

    // Out-of-order completion, in-order release, two-cycle latency
    bus.resultReady = 1'b1;
    issue(1'b1, 6'd7);
    check("tag_after_one", 32'(bus.issueTag), 32'd1);
    issue(1'b0, 6'd3);
    issue(1'b1, 6'd5);
    check("occ_three", 32'(bus.occupancy), 32'd3);
    lane_write(2'b11, 9'd2, 9'd0, 6'd5, 6'd7);
    check("lat_edge_t", 32'(bus.resultValid), 32'd0);
    tick();
    check("lat_edge_t1", 32'(bus.resultValid), 32'd1);
    lane_write(2'b01, 9'd1, 9'd0, 6'd3, 6'd0);
    drain(20);
    check("basic_no_err", 32'(bus.protocolError), 32'd0);
    check("basic_occ", 32'(bus.occupancy), 32'd0);

    // Duplicate tag from both lanes: lane 0 wins, error flagged
    issue(1'b0, 6'd20);
    issue(1'b1, 6'd9);
    lane_write(2'b11, 9'd4, 9'd4, 6'd9, 6'd11);
    check("dup_err", 32'(bus.protocolError), 32'd1);
    lane_write(2'b01, 9'd3, 9'd0, 6'd20, 6'd0);
    drain(20);

    do_reset();
    check("rst2_err", 32'(bus.protocolError), 32'd0);
    check("rst2_tag", 32'(bus.issueTag), 32'd0);

    // Backpressure holds the output stable, then pops stream without bubbles
    bus.resultReady = 1'b0;
    issue(1'b1, 6'd30);
    issue(1'b0, 6'd31);
    issue(1'b1, 6'd32);
    lane_write(2'b11, 9'd0, 9'd1, 6'd30, 6'd31);
    lane_write(2'b01, 9'd2, 9'd0, 6'd32, 6'd0);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(bus.resultValid), 32'd1);
      check("hold_result", 32'(bus.result), 32'd30);
      check("hold_extra", 32'(bus.extraDataOut), 32'd1);
      tick();
    end
    bus.resultReady = 1'b1;
    tick();
    check("nobubble_valid1", 32'(bus.resultValid), 32'd1);
    check("nobubble_result1", 32'(bus.result), 32'd31);
    tick();
    check("nobubble_valid2", 32'(bus.resultValid), 32'd1);
    check("nobubble_result2", 32'(bus.result), 32'd32);
    drain(20);

    // Fill all slots with nothing completing; tail starts at tag 3
    bus.resultReady = 1'b0;
    bus.issueValid  = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == 499) begin
        check("slow_at_499", 32'(bus.slowDownInput), 32'd0);
        check("occ_499", 32'(bus.occupancy), 32'd499);
      end
      if (i == 500) begin
        check("slow_at_500", 32'(bus.slowDownInput), 32'd1);
        check("occ_500", 32'(bus.occupancy), 32'd500);
      end
    end
    check("full_occ", 32'(bus.occupancy), 32'd512);
    check("full_no_err", 32'(bus.protocolError), 32'd0);
    check("full_tag", 32'(bus.issueTag), 32'd3);
    tick();
    bus.issueValid = 1'b0;
    check("overflow_err", 32'(bus.protocolError), 32'd1);
    check("overflow_occ", 32'(bus.occupancy), 32'd512);
    check("overflow_tag", 32'(bus.issueTag), 32'd3);

    // Reset with ten slots in flight, then a late completion
    do_reset();
    bus.issueValid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.issueValid = 1'b0;
    check("inflight_occ", 32'(bus.occupancy), 32'd10);
    do_reset();
    check("midrst_occ", 32'(bus.occupancy), 32'd0);
    check("midrst_err", 32'(bus.protocolError), 32'd0);
    bus.resultReady = 1'b1;
    lane_write(2'b01, 9'd3, 9'd0, 6'd1, 6'd0);
    check("late_write_err", 32'(bus.protocolError), 32'd1);
    check("late_write_valid", 32'(bus.resultValid), 32'd0);
    tick();
    check("late_write_valid2", 32'(bus.resultValid), 32'd0);

    // Randomized traffic long enough to wrap the tag space
    do_reset();
    model_tail = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      idle_lanes();
      if (pend_tag.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, pend_tag.size() - 1));
        bus.laneWriteValid[0]       = 1'b1;
        bus.laneWriteTag[AW-1:0]    = pend_tag[idx];
        bus.laneWriteResult[RW-1:0] = pend_res[idx];
        pend_tag.delete(idx);
        pend_res.delete(idx);
      end
      if (pend_tag.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, pend_tag.size() - 1));
        bus.laneWriteValid[1]          = 1'b1;
        bus.laneWriteTag[2*AW-1:AW]    = pend_tag[idx];
        bus.laneWriteResult[2*RW-1:RW] = pend_res[idx];
        pend_tag.delete(idx);
        pend_res.delete(idx);
      end
      bus.resultReady = ($urandom_range(0, 3) != 0);
      if (!bus.slowDownInput && $urandom_range(0, 9) < 6) begin
        check("wrap_issue_tag", 32'(bus.issueTag), 32'(model_tail));
        rnd_res   = RW'($urandom);
        rnd_extra = EW'($urandom);
        bus.issueValid  = 1'b1;
        bus.extraDataIn = rnd_extra;
        sb.push_back(exp_t'{res: rnd_res, extra: rnd_extra});
        pend_tag.push_back(AW'(model_tail));
        pend_res.push_back(rnd_res);
        model_tail = (model_tail + 1) % DEPTH;
      end else begin
        bus.issueValid = 1'b0;
      end
      tick();
    end
    bus.issueValid = 1'b0;
    idle_lanes();
    for (int n = 0; n < 2000 && pend_tag.size() > 0; n++) begin
      lane_write(2'b01, pend_tag[0], 9'd0, pend_res[0], 6'd0);
      pend_tag.delete(0);
      pend_res.delete(0);
    end
    drain(2000);
    check("wrap_no_err", 32'(bus.protocolError), 32'd0);
    check("wrap_occ", 32'(bus.occupancy), 32'd0);
    check("wrap_final_tag", 32'(bus.issueTag), 32'(model_tail));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
